// File: rtl/run_control_pkg.sv
// Shared types for the run-control block: FSM states and latched halt causes.
// No logic here; imported by run_control.
package run_control_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RESETTING = 2'd1,
        RUNNING   = 2'd2,
        DONE      = 2'd3
    } run_state_t;

    typedef enum logic [1:0] {
        NONE          = 2'd0,
        CYCLE_LIMIT   = 2'd1,
        IDLE_WATCHDOG = 2'd2,
        HALT_REQUEST  = 2'd3
    } halt_cause_t;

endpackage

// File: rtl/run_control_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
// Latency: count updates on the enabling edge; no backpressure.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Clear,
    input  logic             Enable,
    output logic [WIDTH-1:0] Count
);

    always_ff @(posedge Clock) begin
        if (Reset || Clear) begin
            Count <= '0;
        end else if (Enable && (Count != '1)) begin
            Count <= Count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/run_control.sv
// Core reset sequencer and perf monitor; ends a run on halt, cycle limit or retire-idle watchdog.
// Latency: all outputs registered, stop condition visible one edge after it is sampled; no backpressure.
module run_control #(
    parameter int COUNT_WIDTH  = 32,
    parameter int NUM_EVENTS   = 4,
    parameter int RESET_CYCLES = 4,
    parameter int CYCLE_LIMIT  = 2000000,
    parameter int IDLE_LIMIT   = 1024,
    parameter int AUTO_START   = 1
) (
    input  logic                              Clock,
    input  logic                              Reset,
    input  logic                              Start,
    input  logic                              HaltRequest,
    input  logic                              Retire,
    input  logic [NUM_EVENTS-1:0]             Events,
    output logic                              CoreReset,
    output logic                              Running,
    output logic                              Done,
    output logic [1:0]                        HaltCause,
    output logic [COUNT_WIDTH-1:0]            CycleCount,
    output logic [COUNT_WIDTH-1:0]            RetireCount,
    output logic [NUM_EVENTS*COUNT_WIDTH-1:0] EventCounts
);
    import run_control_pkg::*;

    localparam int                RW       = $clog2(RESET_CYCLES + 1);
    localparam logic [RW-1:0]     RST_LAST = RW'(RESET_CYCLES - 1);
    localparam logic [63:0]       CYC_LIM  = 64'(CYCLE_LIMIT);
    localparam logic [63:0]       IDL_LIM  = 64'(IDLE_LIMIT);

    run_state_t                 state_q, state_d;
    halt_cause_t                cause_q, cause_d;
    logic [RW-1:0]              rst_cnt_q;
    logic                       in_reset_q;
    logic                       restart;
    logic                       running_en;
    logic                       hit_cycle, hit_idle;
    logic [COUNT_WIDTH-1:0]     idle_cnt;
    logic [COUNT_WIDTH-1:0]     cycle_inc, idle_inc;

    assign running_en = (state_q == RUNNING);

    // Stop conditions look at the post-increment values so the triggering cycle is counted.
    assign cycle_inc = (CycleCount == '1) ? CycleCount : CycleCount + COUNT_WIDTH'(1);
    assign idle_inc  = Retire ? '0 : ((idle_cnt == '1) ? idle_cnt : idle_cnt + COUNT_WIDTH'(1));
    assign hit_cycle = (CYCLE_LIMIT != 0) && (64'(cycle_inc) == CYC_LIM);
    assign hit_idle  = (IDLE_LIMIT != 0) && (64'(idle_inc) == IDL_LIM);

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        restart = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start || ((AUTO_START != 0) && in_reset_q)) begin
                    state_d = RESETTING;
                    restart = 1'b1;
                end
            end
            RESETTING: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = RUNNING;
                end
            end
            RUNNING: begin
                if (HaltRequest) begin
                    state_d = DONE;
                    cause_d = run_control_pkg::HALT_REQUEST;
                end else if (hit_cycle) begin
                    state_d = DONE;
                    cause_d = run_control_pkg::CYCLE_LIMIT;
                end else if (hit_idle) begin
                    state_d = DONE;
                    cause_d = run_control_pkg::IDLE_WATCHDOG;
                end
            end
            DONE: begin
                if (Start) begin
                    state_d = RESETTING;
                    restart = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (restart) begin
            cause_d = run_control_pkg::NONE;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            cause_q    <= run_control_pkg::NONE;
            rst_cnt_q  <= '0;
            in_reset_q <= 1'b1;
            CoreReset  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            in_reset_q <= 1'b0;
            CoreReset  <= (state_d != RUNNING);
            rst_cnt_q  <= (state_q == RESETTING) ? rst_cnt_q + RW'(1) : '0;
        end
    end

    assign Running   = (state_q == RUNNING);
    assign Done      = (state_q == DONE);
    assign HaltCause = cause_q;

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_cycle (
        .Clock(Clock), .Reset(Reset), .Clear(restart),
        .Enable(running_en), .Count(CycleCount)
    );

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_retire (
        .Clock(Clock), .Reset(Reset), .Clear(restart),
        .Enable(running_en && Retire), .Count(RetireCount)
    );

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_idle (
        .Clock(Clock), .Reset(Reset), .Clear(restart || (running_en && Retire)),
        .Enable(running_en), .Count(idle_cnt)
    );

    for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_evt
        sat_counter #(.WIDTH(COUNT_WIDTH)) u_evt (
            .Clock(Clock), .Reset(Reset), .Clear(restart),
            .Enable(running_en && Events[i]),
            .Count(EventCounts[i*COUNT_WIDTH +: COUNT_WIDTH])
        );
    end

endmodule

// File: tb/tb_run_control.sv
// Bench for run_control: directed scenarios plus randomized runs against a cycle-level run model.
module tb_run_control;
    localparam int CW = 8;
    localparam int NE = 4;
    localparam int RC = 4;
    localparam int CL = 100;
    localparam int IL = 8;
    localparam int BW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, halt, retire;
    logic [NE-1:0] events;
    logic core_reset, running, done;
    logic [1:0] cause;
    logic [CW-1:0] cyc, ret;
    logic [NE*CW-1:0] evc;

    logic b_rst, b_start, b_halt, b_retire;
    logic [NE-1:0] b_events;
    logic b_core_reset, b_running, b_done;
    logic [1:0] b_cause;
    logic [BW-1:0] b_cyc, b_ret;
    logic [NE*BW-1:0] b_evc;

    int checks = 0;
    int errors = 0;

    run_control #(.COUNT_WIDTH(CW), .NUM_EVENTS(NE), .RESET_CYCLES(RC),
                  .CYCLE_LIMIT(CL), .IDLE_LIMIT(IL), .AUTO_START(1)) dut (
        .Clock(clk), .Reset(rst), .Start(start), .HaltRequest(halt), .Retire(retire),
        .Events(events), .CoreReset(core_reset), .Running(running), .Done(done),
        .HaltCause(cause), .CycleCount(cyc), .RetireCount(ret), .EventCounts(evc)
    );

    run_control #(.COUNT_WIDTH(BW), .NUM_EVENTS(NE), .RESET_CYCLES(RC),
                  .CYCLE_LIMIT(0), .IDLE_LIMIT(0), .AUTO_START(0)) dut_b (
        .Clock(clk), .Reset(b_rst), .Start(b_start), .HaltRequest(b_halt), .Retire(b_retire),
        .Events(b_events), .CoreReset(b_core_reset), .Running(b_running), .Done(b_done),
        .HaltCause(b_cause), .CycleCount(b_cyc), .RetireCount(b_ret), .EventCounts(b_evc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ev_a(input int i);
        return int'(evc[i*CW +: CW]);
    endfunction

    function automatic int ev_b(input int i);
        return int'(b_evc[i*BW +: BW]);
    endfunction

    task automatic clear_inputs();
        start = 0; halt = 0; retire = 0; events = '0;
    endtask

    // Start pulse from IDLE/DONE, then the reset window must last exactly RC edges.
    task automatic start_run(input string tag);
        start = 1;
        step();
        start = 0;
        checks++;
        if (done !== 0 || cause !== 0 || cyc !== 0 || ret !== 0 || core_reset !== 1 || running !== 0) begin
            errors++;
            $display("FAIL %s_restart_state got done=%0d cause=%0d cyc=%0d ret=%0d crst=%0d run=%0d want 0 0 0 0 1 0",
                     tag, done, cause, cyc, ret, core_reset, running);
        end
        repeat (RC - 1) step();
        checks++;
        if (running !== 0 || core_reset !== 1) begin
            errors++;
            $display("FAIL %s_reset_window got run=%0d crst=%0d want 0 1", tag, running, core_reset);
        end
        step();
        checks++;
        if (running !== 1 || core_reset !== 0) begin
            errors++;
            $display("FAIL %s_run_rise got run=%0d crst=%0d want 1 0", tag, running, core_reset);
        end
    endtask

    task automatic test_reset();
        rst = 1; b_rst = 1;
        clear_inputs();
        b_start = 0; b_halt = 0; b_retire = 0; b_events = '0;
        step(); step();
        checks++;
        if (core_reset !== 1 || running !== 0 || done !== 0 || cause !== 0 || cyc !== 0 || ret !== 0 || evc !== '0) begin
            errors++;
            $display("FAIL reset_values got crst=%0d run=%0d done=%0d cause=%0d cyc=%0d ret=%0d want 1 0 0 0 0 0",
                     core_reset, running, done, cause, cyc, ret);
        end
        rst = 0; b_rst = 0;
        step();
        checks++;
        if (core_reset !== 1 || running !== 0) begin
            errors++;
            $display("FAIL release_edge got crst=%0d run=%0d want 1 0", core_reset, running);
        end
        for (int k = 1; k < RC; k++) begin
            step();
            checks++;
            if (core_reset !== 1 || running !== 0) begin
                errors++;
                $display("FAIL auto_start_window edge %0d got crst=%0d run=%0d want 1 0", k, core_reset, running);
            end
        end
        step();
        checks++;
        if (core_reset !== 0 || running !== 1 || cyc !== 0 || ret !== 0 || evc !== '0) begin
            errors++;
            $display("FAIL auto_start_run got crst=%0d run=%0d cyc=%0d ret=%0d want 0 1 0 0", core_reset, running, cyc, ret);
        end
    endtask

    task automatic test_cycle_limit();
        retire = 1;
        repeat (CL - 1) step();
        checks++;
        if (running !== 1 || done !== 0) begin
            errors++;
            $display("FAIL cycle_limit_early got run=%0d done=%0d want 1 0", running, done);
        end
        step();
        retire = 0;
        checks++;
        if (done !== 1 || cause !== 1 || cyc !== CW'(CL) || ret !== CW'(CL) || core_reset !== 1) begin
            errors++;
            $display("FAIL cycle_limit got done=%0d cause=%0d cyc=%0d ret=%0d crst=%0d want 1 1 %0d %0d 1",
                     done, cause, cyc, ret, core_reset, CL, CL);
        end
    endtask

    task automatic test_restart();
        retire = 1; halt = 1; events = '1;
        repeat (3) step();
        clear_inputs();
        checks++;
        if (done !== 1 || cyc !== CW'(CL) || ret !== CW'(CL) || evc !== '0 || cause !== 1) begin
            errors++;
            $display("FAIL done_frozen got done=%0d cyc=%0d ret=%0d evc=%0h cause=%0d want 1 %0d %0d 0 1",
                     done, cyc, ret, evc, cause, CL, CL);
        end
        start_run("restart");
    endtask

    task automatic test_idle();
        retire = 1;
        repeat (3) step();
        retire = 0;
        repeat (IL - 1) step();
        checks++;
        if (running !== 1) begin
            errors++;
            $display("FAIL idle_early got run=%0d want 1", running);
        end
        step();
        checks++;
        if (done !== 1 || cause !== 2 || cyc !== 11 || ret !== 3) begin
            errors++;
            $display("FAIL idle_watchdog got done=%0d cause=%0d cyc=%0d ret=%0d want 1 2 11 3", done, cause, cyc, ret);
        end
    endtask

    task automatic test_halt_with_limit();
        start_run("halt_limit");
        retire = 1;
        repeat (CL - 1) step();
        halt = 1;
        step();
        clear_inputs();
        checks++;
        if (done !== 1 || cause !== 3 || cyc !== CW'(CL)) begin
            errors++;
            $display("FAIL halt_priority got done=%0d cause=%0d cyc=%0d want 1 3 %0d", done, cause, cyc, CL);
        end
    endtask

    task automatic test_halt_first();
        start_run("halt_first");
        halt = 1;
        step();
        clear_inputs();
        checks++;
        if (done !== 1 || cause !== 3 || cyc !== 1 || ret !== 0) begin
            errors++;
            $display("FAIL halt_first got done=%0d cause=%0d cyc=%0d ret=%0d want 1 3 1 0", done, cause, cyc, ret);
        end
    endtask

    task automatic test_start_ignored();
        start = 1;
        step();
        repeat (RC - 1) step();
        checks++;
        if (running !== 0) begin
            errors++;
            $display("FAIL start_in_resetting got run=%0d want 0", running);
        end
        step();
        checks++;
        if (running !== 1) begin
            errors++;
            $display("FAIL start_held_run got run=%0d want 1", running);
        end
        retire = 1;
        repeat (5) step();
        checks++;
        if (running !== 1 || cyc !== 5 || ret !== 5) begin
            errors++;
            $display("FAIL start_in_running got run=%0d cyc=%0d ret=%0d want 1 5 5", running, cyc, ret);
        end
        start = 0; retire = 0; halt = 1;
        step();
        clear_inputs();
        checks++;
        if (cause !== 3 || cyc !== 6) begin
            errors++;
            $display("FAIL start_ignored_end got cause=%0d cyc=%0d want 3 6", cause, cyc);
        end
    endtask

    task automatic test_random(input int runs);
        for (int r = 0; r < runs; r++) begin
            int m_cyc, m_ret, m_idle, m_cause, pct;
            int m_ev[NE];
            logic h, t;
            logic [NE-1:0] e;
            start_run("rand");
            m_cyc = 0; m_ret = 0; m_idle = 0; m_cause = 0;
            for (int i = 0; i < NE; i++) m_ev[i] = 0;
            pct = $urandom_range(30, 100);
            while (m_cause == 0) begin
                t = ($urandom_range(0, 99) < pct);
                h = ($urandom_range(0, 99) < 3);
                e = NE'($urandom);
                retire = t; halt = h; events = e;
                start = ($urandom_range(0, 9) == 0);
                step();
                m_cyc++;
                if (t) begin m_ret++; m_idle = 0; end
                else m_idle++;
                for (int i = 0; i < NE; i++) if (e[i]) m_ev[i]++;
                if (h) m_cause = 3;
                else if (m_cyc == CL) m_cause = 1;
                else if (m_idle == IL) m_cause = 2;
                if (m_cause == 0) begin
                    checks++;
                    if (running !== 1) begin
                        errors++;
                        $display("FAIL rand_running run %0d cycle %0d got %0d want 1", r, m_cyc, running);
                    end
                end
            end
            clear_inputs();
            checks++;
            if (done !== 1 || int'(cause) != m_cause || int'(cyc) != m_cyc || int'(ret) != m_ret) begin
                errors++;
                $display("FAIL rand_end run %0d got done=%0d cause=%0d cyc=%0d ret=%0d want 1 %0d %0d %0d",
                         r, done, cause, cyc, ret, m_cause, m_cyc, m_ret);
            end
            for (int i = 0; i < NE; i++) begin
                checks++;
                if (ev_a(i) != m_ev[i]) begin
                    errors++;
                    $display("FAIL rand_event run %0d ch %0d got %0d want %0d", r, i, ev_a(i), m_ev[i]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        start_run("mid_reset");
        retire = 1; events = '1;
        repeat (5) step();
        rst = 1;
        step();
        clear_inputs();
        checks++;
        if (running !== 0 || done !== 0 || core_reset !== 1 || cause !== 0 || cyc !== 0 || ret !== 0 || evc !== '0) begin
            errors++;
            $display("FAIL mid_reset got run=%0d done=%0d crst=%0d cause=%0d cyc=%0d ret=%0d want 0 0 1 0 0 0",
                     running, done, core_reset, cause, cyc, ret);
        end
        rst = 0;
        step();
    endtask

    task automatic test_saturate();
        checks++;
        if (b_running !== 0 || b_core_reset !== 1 || b_done !== 0) begin
            errors++;
            $display("FAIL no_auto_start got run=%0d crst=%0d done=%0d want 0 1 0", b_running, b_core_reset, b_done);
        end
        b_start = 1;
        step();
        b_start = 0;
        repeat (RC) step();
        checks++;
        if (b_running !== 1 || b_core_reset !== 0) begin
            errors++;
            $display("FAIL b_run_rise got run=%0d crst=%0d want 1 0", b_running, b_core_reset);
        end
        b_events = 4'b0100;
        repeat (30) step();
        b_events = '0;
        for (int i = 0; i < NE; i++) begin
            checks++;
            if (ev_b(i) != ((i == 2) ? 15 : 0)) begin
                errors++;
                $display("FAIL saturate_event ch %0d got %0d want %0d", i, ev_b(i), (i == 2) ? 15 : 0);
            end
        end
        checks++;
        if (b_cyc !== 4'hF || b_running !== 1 || b_done !== 0) begin
            errors++;
            $display("FAIL saturate_cycle got cyc=%0d run=%0d done=%0d want 15 1 0", b_cyc, b_running, b_done);
        end
        b_rst = 1;
        step();
        b_rst = 0;
        checks++;
        if (b_running !== 0 || b_core_reset !== 1 || b_cyc !== 0 || b_evc !== '0) begin
            errors++;
            $display("FAIL b_mid_reset got run=%0d crst=%0d cyc=%0d evc=%0h want 0 1 0 0", b_running, b_core_reset, b_cyc, b_evc);
        end
    endtask

    initial begin
        test_reset();
        test_cycle_limit();
        test_restart();
        test_idle();
        test_halt_with_limit();
        test_halt_first();
        test_start_ignored();
        test_random(25);
        test_mid_reset();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
